// File: rtl/aes_core_ed.sv
// Iterative AES-128 encrypt/decrypt core with on-chip key expansion and round-key store.
// Optional zeroize input and clearing logic enabled by defining AES_CORE_ZEROIZE_EN.
module aes_core_ed #(
    parameter int UNROLL = 1,
    parameter int NR     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key,
    output logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES_CORE_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
        $error("aes_core_ed: UNROLL must be 1 or 2");
    end
    if (NR != 10) begin : g_bad_nr
        $error("aes_core_ed: NR must be 10 for AES-128");
    end

    localparam logic [3:0] Step    = 4'(UNROLL);
    localparam logic [3:0] LastRnd = 4'(NR);

    typedef enum logic [1:0] {StIdle, StKexp, StRun, StOut} state_e;

    state_e       st_q, st_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         mode_q, mode_d;
    logic         key_ready_q, key_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] kb_q [NR+1];
    logic [127:0] kb_d [NR+1];
    logic [127:0] rnd_blk;
    logic [127:0] exp_key;
    logic [3:0]   rr;
    logic         last_step;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127-8*n -: 8] = inv ? inv_sbox(s[127-8*n -: 8]) : sbox(s[127-8*n -: 8]);
        end
        return o;
    endfunction

    // Byte n sits at row n%4, column n/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
                else     o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m [4];
        logic [7:0]   b;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gf_mul(a[(r+j)%4], m[j]);
                o[127-8*(4*c+r) -: 8] = b;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (!last) t = mix_columns(t, 1'b0);
        return t ^ k;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!last) t = mix_columns(t, 1'b1);
        return t;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One expansion step per KEXP cycle: derives kb[cnt] from kb[cnt-1].
    always_comb begin
        logic [127:0] prev;
        logic [31:0]  w3;
        logic [31:0]  t;
        logic [31:0]  n0, n1, n2, n3;
        prev = kb_q[cnt_q - 4'd1];
        w3   = prev[31:0];
        t    = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon(cnt_q), 24'h000000};
        n0   = prev[127:96] ^ t;
        n1   = prev[95:64] ^ n0;
        n2   = prev[63:32] ^ n1;
        n3   = prev[31:0] ^ n2;
        exp_key = {n0, n1, n2, n3};
    end

    always_comb begin
        rnd_blk = blk_q;
        rr      = cnt_q;
        for (int u = 0; u < UNROLL; u++) begin
            rr = cnt_q + 4'(u);
            if (mode_q) rnd_blk = dec_round(rnd_blk, kb_q[LastRnd - rr], rr == LastRnd);
            else        rnd_blk = enc_round(rnd_blk, kb_q[rr], rr == LastRnd);
        end
    end

    assign last_step = (cnt_q + Step) > LastRnd;
    assign in_ready  = (st_q == StIdle) && key_ready_q && !key_load;

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        key_ready_d = key_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        blk_d       = blk_q;
        kb_d        = kb_q;
        case (st_q)
            StIdle: begin
                if (key_load) begin
                    kb_d[0]     = key;
                    key_ready_d = 1'b0;
                    cnt_d       = 4'd1;
                    st_d        = StKexp;
                end else if (in_valid && in_ready) begin
                    blk_d  = in_data ^ (in_mode ? kb_q[NR] : kb_q[0]);
                    mode_d = in_mode;
                    cnt_d  = 4'd1;
                    st_d   = StRun;
                end
            end
            StKexp: begin
                kb_d[cnt_q] = exp_key;
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == LastRnd) begin
                    key_ready_d = 1'b1;
                    st_d        = StIdle;
                end
            end
            StRun: begin
                blk_d = rnd_blk;
                cnt_d = cnt_q + Step;
                if (last_step) begin
                    out_data_d  = rnd_blk;
                    out_valid_d = 1'b1;
                    st_d        = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    st_d        = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
`ifdef AES_CORE_ZEROIZE_EN
        if (zeroize) begin
            st_d        = StIdle;
            key_ready_d = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            blk_d       = '0;
            for (int k = 0; k <= NR; k++) kb_d[k] = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q        <= StIdle;
            cnt_q       <= 4'd0;
            mode_q      <= 1'b0;
            key_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            key_ready_q <= key_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Datapath storage is not reset; key_ready gates any use of stale contents.
    always_ff @(posedge clk) begin
        blk_q <= blk_d;
        kb_q  <= kb_d;
    end

    assign key_ready = key_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (st_q != StIdle);

endmodule

// File: tb/tb_aes_core_ed.sv
// Bench for aes_core_ed: one UNROLL=1 and one UNROLL=2 instance against a byte-level AES model.
// Covers the zeroize input as well when AES_CORE_ZEROIZE_EN is defined.
module tb_aes_core_ed;

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam int PhIdle = 0;
    localparam int PhKexp = 1;
    localparam int PhRun  = 2;
    localparam int PhOut  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst;
    logic [1:0]        key_load;
    logic [1:0][127:0] key;
    logic [1:0]        in_valid;
    logic [1:0]        in_mode;
    logic [1:0][127:0] in_data;
    logic [1:0]        out_ready;
    wire  [1:0]        key_ready;
    wire  [1:0]        in_ready;
    wire  [1:0]        out_valid;
    wire  [1:0][127:0] out_data;
    wire  [1:0]        busy;
`ifdef AES_CORE_ZEROIZE_EN
    logic [1:0]        zeroize;
`endif

    int checks = 0;
    int errors = 0;

    aes_core_ed #(.UNROLL(1), .NR(10)) u_dut1 (
        .clk(clk), .rst(rst[0]), .key_load(key_load[0]), .key(key[0]),
        .key_ready(key_ready[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_mode(in_mode[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]),
`ifdef AES_CORE_ZEROIZE_EN
        .zeroize(zeroize[0]),
`endif
        .busy(busy[0])
    );

    aes_core_ed #(.UNROLL(2), .NR(10)) u_dut2 (
        .clk(clk), .rst(rst[1]), .key_load(key_load[1]), .key(key[1]),
        .key_ready(key_ready[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_mode(in_mode[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]),
`ifdef AES_CORE_ZEROIZE_EN
        .zeroize(zeroize[1]),
`endif
        .busy(busy[1])
    );

    // ---------------- reference AES (table based, byte arrays) ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse in lock-step.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] d,
                                               input logic dec);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a [4];
        logic [7:0] tmp [4];
        logic [7:0] rc, x0;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = d[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                x0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[x0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        if (!dec) begin
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[j];
            for (int r = 1; r <= 10; r++) begin
                for (int j = 0; j < 16; j++) t[j] = sb[s[(j%4) + 4*(((j/4) + (j%4)) % 4)]];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int q = 0; q < 4; q++) a[q] = t[4*c+q];
                        s[4*c]   = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
                        s[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
                        s[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
                        s[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
                    end
                end else begin
                    s = t;
                end
                for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[16*r+j];
            end
        end else begin
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[160+j];
            for (int r = 9; r >= 0; r--) begin
                for (int j = 0; j < 16; j++) t[(j%4) + 4*(((j/4) + (j%4)) % 4)] = isb[s[j]];
                for (int j = 0; j < 16; j++) s[j] = t[j] ^ w[16*r+j];
                if (r > 0) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int q = 0; q < 4; q++) a[q] = s[4*c+q];
                        for (int q = 0; q < 4; q++) begin
                            s[4*c+q] = gm(a[q], 8'h0e) ^ gm(a[(q+1)%4], 8'h0b)
                                     ^ gm(a[(q+2)%4], 8'h0d) ^ gm(a[(q+3)%4], 8'h09);
                        end
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- transaction-level model of the core ----------------
    int           m_phase [2];
    int           m_cnt   [2];
    bit           m_kr    [2];
    bit           m_ov    [2];
    bit           m_odchk [2];
    bit           m_armed [2];
    logic [127:0] m_key   [2];
    logic [127:0] m_res   [2];
    logic [127:0] m_od    [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = PhIdle;
            m_cnt[i]   = 0;
            m_kr[i]    = 0;
            m_ov[i]    = 0;
            m_odchk[i] = 0;
            m_armed[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                m_phase[i] <= PhIdle;
                m_kr[i]    <= 0;
                m_ov[i]    <= 0;
                m_od[i]    <= '0;
                m_odchk[i] <= 1;
                m_armed[i] <= 1;
`ifdef AES_CORE_ZEROIZE_EN
            end else if (zeroize[i]) begin
                m_phase[i] <= PhIdle;
                m_kr[i]    <= 0;
                m_ov[i]    <= 0;
                m_od[i]    <= '0;
                m_odchk[i] <= 1;
`endif
            end else begin
                case (m_phase[i])
                    PhIdle: begin
                        if (key_load[i]) begin
                            m_phase[i] <= PhKexp;
                            m_cnt[i]   <= 10;
                            m_kr[i]    <= 0;
                            m_key[i]   <= key[i];
                        end else if (in_valid[i] && m_kr[i]) begin
                            m_phase[i] <= PhRun;
                            m_cnt[i]   <= (i == 0) ? 10 : 5;
                            m_res[i]   <= aes_model(m_key[i], in_data[i], in_mode[i]);
                        end
                    end
                    PhKexp: begin
                        m_cnt[i] <= m_cnt[i] - 1;
                        if (m_cnt[i] == 1) begin
                            m_phase[i] <= PhIdle;
                            m_kr[i]    <= 1;
                        end
                    end
                    PhRun: begin
                        m_cnt[i] <= m_cnt[i] - 1;
                        if (m_cnt[i] == 1) begin
                            m_phase[i] <= PhOut;
                            m_ov[i]    <= 1;
                            m_od[i]    <= m_res[i];
                            m_odchk[i] <= 1;
                        end
                    end
                    default: begin
                        if (out_ready[i]) begin
                            m_phase[i] <= PhIdle;
                            m_ov[i]    <= 0;
                            m_odchk[i] <= 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_armed[i]) begin
                chk($sformatf("key_ready[%0d]", i), key_ready[i], m_kr[i]);
                chk($sformatf("in_ready[%0d]", i), in_ready[i],
                    (m_phase[i] == PhIdle) && m_kr[i] && !key_load[i]);
                chk($sformatf("out_valid[%0d]", i), out_valid[i], m_ov[i]);
                chk($sformatf("busy[%0d]", i), busy[i], m_phase[i] != PhIdle);
                if (m_odchk[i]) chk($sformatf("out_data[%0d]", i), out_data[i], m_od[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int i, input logic [127:0] k, input logic with_valid);
        int n;
        key_load[i] = 1'b1;
        key[i]      = k;
        in_valid[i] = with_valid;
        in_data[i]  = PB;
        #1;
        chk("key_load_blocks_in_ready", in_ready[i], 1'b0);
        tick();
        key_load[i] = 1'b0;
        in_valid[i] = 1'b0;
        n = 0;
        while (key_ready[i] !== 1'b1 && n < 20) begin
            chk("kexp_key_ready_low", key_ready[i], 1'b0);
            tick();
            n++;
        end
        chk("kexp_latency", n, 10);
        chk("kexp_idle_after", busy[i], 1'b0);
    endtask

    task automatic send_block(input int i, input logic [127:0] d, input logic m);
        int n;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_mode[i]  = m;
        #1;
        n = 0;
        while (in_ready[i] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("accept_in_ready", in_ready[i], 1'b1);
        tick();
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_out(input int i, output int n);
        n = 0;
        while (out_valid[i] !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_out(input int i, input int hold, output logic [127:0] res);
        res = out_data[i];
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("bp_out_valid_held", out_valid[i], 1'b1);
            chk("bp_out_data_stable", out_data[i], res);
            chk("bp_in_ready_low", in_ready[i], 1'b0);
        end
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
        chk("hs_out_valid_low", out_valid[i], 1'b0);
        chk("hs_in_ready_next", in_ready[i], 1'b1);
    endtask

    task automatic run_block(input int i, input logic [127:0] d, input logic m, input int lat,
                             input int hold, input logic [127:0] exp, input string nm);
        int n;
        logic [127:0] res;
        send_block(i, d, m);
        wait_out(i, n);
        chk({nm, "_latency"}, n, lat);
        finish_out(i, hold, res);
        chk({nm, "_data"}, res, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [127:0] res;
        rst       = 2'b00;
        key_load  = '0;
        key       = '0;
        in_valid  = '0;
        in_mode   = '0;
        in_data   = '0;
        out_ready = '0;
`ifdef AES_CORE_ZEROIZE_EN
        zeroize   = '0;
`endif
        build_sbox();
        chk("model_sbox_53", sb[8'h53], 8'hed);
        chk("model_enc_fips_b", aes_model(KB, PB, 1'b0), CB);
        chk("model_dec_fips_c1", aes_model(KC, CC, 1'b1), PC);
        chk("model_enc_fips_c1", aes_model(KC, PC, 1'b0), CC);

        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_key_ready", key_ready[i], 1'b0);
            chk("rst_in_ready", in_ready[i], 1'b0);
            chk("rst_out_valid", out_valid[i], 1'b0);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_out_data", out_data[i], 128'h0);
        end
        rst = 2'b11;

        // No key yet: block must be refused.
        in_valid[0] = 1'b1;
        in_data[0]  = PB;
        repeat (3) begin
            tick();
            chk("nokey_in_ready", in_ready[0], 1'b0);
            chk("nokey_busy", busy[0], 1'b0);
        end
        in_valid[0] = 1'b0;

        load_key(0, KB, 1'b0);
        // key_load wins over a same-cycle in_valid while a key is present.
        load_key(0, KB, 1'b1);
        run_block(0, PB, 1'b0, 10, 7, CB, "enc_b_u1_bp");

        // key_load during RUN is ignored; result uses the old key.
        send_block(0, PB, 1'b0);
        tick();
        key_load[0] = 1'b1;
        key[0]      = KC;
        tick();
        key_load[0] = 1'b0;
        wait_out(0, n);
        chk("kl_in_run_latency", n, 8);
        finish_out(0, 0, res);
        chk("kl_in_run_data", res, CB);
        chk("kl_in_run_key_ready", key_ready[0], 1'b1);

        run_block(0, CB, 1'b1, 10, 0, PB, "dec_b_u1");

        load_key(1, KC, 1'b0);
        run_block(1, CC, 1'b1, 5, 2, PC, "dec_c1_u2");
        run_block(1, PC, 1'b0, 5, 0, CC, "enc_c1_u2");

        // Reset while round 4 is in progress.
        send_block(0, PB, 1'b0);
        repeat (3) tick();
        rst[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        repeat (12) begin
            chk("midrst_out_valid", out_valid[0], 1'b0);
            chk("midrst_key_ready", key_ready[0], 1'b0);
            chk("midrst_in_ready", in_ready[0], 1'b0);
            tick();
        end
        load_key(0, KB, 1'b0);
        run_block(0, PB, 1'b0, 10, 0, CB, "enc_b_after_rst");

`ifdef AES_CORE_ZEROIZE_EN
        send_block(0, PB, 1'b0);
        wait_out(0, n);
        chk("zr_reach_out", out_valid[0], 1'b1);
        zeroize[0] = 1'b1;
        tick();
        zeroize[0] = 1'b0;
        chk("zr_out_valid", out_valid[0], 1'b0);
        chk("zr_out_data", out_data[0], 128'h0);
        chk("zr_key_ready", key_ready[0], 1'b0);
        chk("zr_busy", busy[0], 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = PB;
        repeat (3) begin
            tick();
            chk("zr_no_accept", in_ready[0], 1'b0);
        end
        in_valid[0] = 1'b0;
        load_key(0, KB, 1'b0);
        run_block(0, PB, 1'b0, 10, 0, CB, "enc_b_after_zr");
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_core_ed.md
Name: aes_core_ed

Overview:
- Iterative AES-128 core with per-block encrypt/decrypt mode selection, an internal key-expansion engine and a round-key store.
- Valid/ready handshakes on both input and output.
- Parametrised rounds-per-cycle: 1 or 2 round datapaths unrolled.
- Next-generation replacement for the separate fixed-function cipher/decipher blocks in the crypto subsystem; reuses the existing sbox and invsbox leaf cells.

Parameters:
- UNROLL, 1, rounds computed per clock; legal values are 1 and 2 (any other value is an elaboration error).
- NR, 10, round count; fixed at 10 for AES-128, exposed for assertions only.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- key_load  input  1  one-cycle pulse; starts key expansion of key.
- key  input  128  cipher key; sampled on the key_load cycle.
- key_ready  output  1  round-key store valid.
- in_valid  input  1  input block valid.
- in_ready  output  1  core can accept a block.
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled with the block.
- in_data  input  128  plaintext or ciphertext; byte 0 = bits [127:120].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  result block.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0 at an edge):
  - FSM goes to IDLE.
  - key_ready=0, in_ready=0, out_valid=0, busy=0, out_data=0.
  - Round-key store contents are undefined after reset; key_ready=0 gates their use.
  - Reset mid-operation abandons the block in flight; no output is produced.
- FSM states: IDLE, KEXP, RUN, OUT.
- IDLE:
  - key_load=1 → KEXP. key_load has priority over a same-cycle in_valid, which is not accepted.
  - Otherwise in_valid & in_ready → RUN.
- key_load is ignored in KEXP, RUN and OUT.
- KEXP:
  - Edge 0 (the key_load edge): kb[0] ← key, key_ready ← 0.
  - Edges 1..10: kb[i] = standard FIPS-197 expansion of kb[i-1], using Rcon 01,02,04,08,10,20,40,80,1b,36 and four sbox instances.
  - Edge 10 returns to IDLE with key_ready ← 1, so key_ready is first seen high in the 11th cycle after key_load.
- in_ready = (state==IDLE) & key_ready & !key_load.
- Accept edge:
  - state ← in_data ^ kb[0] for encrypt, in_data ^ kb[10] for decrypt.
  - Mode is latched; round counter r ← 1.
- RUN, per clock:
  - Apply UNROLL consecutive rounds r, r+1.
  - Encrypt round r: SubBytes, ShiftRows, MixColumns, AddRoundKey kb[r].
  - Decrypt round r: InvShiftRows, InvSubBytes, AddRoundKey kb[10-r], InvMixColumns.
  - Round 10 omits (Inv)MixColumns in both modes.
  - Counter advances by UNROLL.
  - The edge that completes round 10 loads out_data, sets out_valid=1 and moves to OUT.
- Latency: out_valid rises NR/UNROLL edges after the accept edge (10 for UNROLL=1, 5 for UNROLL=2).
- OUT:
  - out_data is held stable while out_valid=1 & out_ready=0.
  - out_valid & out_ready → out_valid ← 0, back to IDLE.
  - in_ready is low in OUT, so no overlap. Next accept is possible one cycle after the handshake.
- Throughput: one block per NR/UNROLL + 2 cycles.
- Key reload between blocks is permitted. Blocks use the key store current at their accept edge; the store cannot change during RUN.
- in_valid while !key_ready: the block is not accepted and in_ready stays 0.

Optional Feature:
- Macro AES_CORE_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - zeroize=1 at an edge, in any state, clears all kb entries, the state register and out_data to 0.
  - Sets key_ready=0, out_valid=0 and returns the FSM to IDLE.
  - Priority: below rst, above key_load and in_valid.
- Undefined: no port, no clearing logic; key store persists until the next key_load.

Test Plan:
- Encrypt FIPS-197 B, UNROLL=1:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3243f6a8885a308d313198a2e0370734.
  - Response: out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
- Decrypt FIPS-197 C.1, UNROLL=2:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, in_mode=1, in_data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out_data 00112233445566778899aabbccddeeff, out_valid 5 edges after accept.
- Backpressure:
  - Stimulus: hold out_ready=0 for 7 cycles after out_valid.
  - Response: out_data stable, in_ready=0 throughout; handshake on cycle 8 returns to IDLE, in_ready=1 next cycle.
- Key sequencing:
  - Stimulus: key_load with in_valid=1 in the same cycle.
  - Response: block not accepted; key_ready=1 at the 11th cycle. key_load issued during RUN is ignored and the result matches the old key.
- Reset mid-RUN:
  - Stimulus: rst=0 at round 4.
  - Response: out_valid never asserted, key_ready=0, in_ready=0; after a new key_load the B vector passes again.
- With AES_CORE_ZEROIZE_EN:
  - Stimulus: zeroize pulse in OUT.
  - Response: out_valid=0, out_data=0 next cycle, key_ready=0; in_valid is not accepted until a new key expansion completes.
